// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART Tx FIFO between N requesters.
// A grant lasts for a whole packet; an owner that goes quiet for TIMEOUT cycles is released.

module uart_tx_arb_lane (
  input  logic       own,
  input  logic       locked,
  input  logic       txq_full,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       grant,
  output logic       ready,
  output logic       fire,
  output logic [7:0] data_sel
);
  assign grant    = locked & own;
  assign ready    = grant & ~txq_full;
  assign fire     = ready & valid;
  assign data_sel = fire ? data : 8'h00;
endmodule

module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           send_req,
  output logic [7:0]     send_data,
  input  logic           txq_full,
  output logic [N-1:0]   grant,
  output logic           timeout_evt
);
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int PW1 = PW + 1;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     g_q, g_d, ptr_q, ptr_d;
  logic [PW-1:0]     win, g_nxt;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              any_valid, own_valid, own_last, locked;
  logic [N-1:0]      fire;
  logic [N-1:0][7:0] data_sel;

  assign locked    = (state_q == LOCKED);
  assign own_valid = req_valid[g_q];
  assign own_last  = req_last[g_q];
  assign g_nxt     = (g_q == PW'(N - 1)) ? '0 : g_q + 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_lane
    uart_tx_arb_lane u_lane (
      .own      (g_q == PW'(i)),
      .locked   (locked),
      .txq_full (txq_full),
      .valid    (req_valid[i]),
      .data     (req_data[8*i +: 8]),
      .grant    (grant[i]),
      .ready    (req_ready[i]),
      .fire     (fire[i]),
      .data_sel (data_sel[i])
    );
  end

  assign send_req = |fire;

  always_comb begin
    send_data = '0;
    for (int i = 0; i < N; i++) send_data = send_data | data_sel[i];
  end

  // Backpressure (owner valid, FIFO full) is not idleness, so only !own_valid can time out.
  assign timeout_evt = locked & ~own_valid & (TIMEOUT != 0) & (tcnt_q == TLIM);

  // First valid requester scanning ptr, ptr+1, ... modulo N.
  always_comb begin
    logic [PW1-1:0] idx;
    idx       = '0;
    any_valid = 1'b0;
    win       = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + PW1'(k);
      if (idx >= PW1'(N)) idx = idx - PW1'(N);
      if (!any_valid && req_valid[idx[PW-1:0]]) begin
        any_valid = 1'b1;
        win       = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = LOCKED;
          g_d     = win;
          tcnt_d  = '0;
        end
      end
      LOCKED: begin
        if (send_req) begin
          tcnt_d = '0;
          if (own_last) begin
            state_d = IDLE;
            ptr_d   = g_nxt;
          end
        end else if (!own_valid && (TIMEOUT != 0)) begin
          if (timeout_evt) begin
            state_d = IDLE;
            ptr_d   = g_nxt;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios on N=2 and N=3 instances plus a
// randomized run on N=2 compared against an owner/pointer/quiet-count reference model.

module tb_uart_tx_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a_valid, a_last, a_ready, a_grant;
  logic [15:0] a_data;
  logic        a_full, a_send, a_evt;
  logic [7:0]  a_sdata;

  logic [2:0]  b_valid, b_last, b_ready, b_grant;
  logic [23:0] b_data;
  logic        b_full, b_send, b_evt;
  logic [7:0]  b_sdata;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(.N(2), .TIMEOUT(TO)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
    .req_ready(a_ready), .send_req(a_send), .send_data(a_sdata), .txq_full(a_full),
    .grant(a_grant), .timeout_evt(a_evt)
  );

  uart_tx_arbiter #(.N(3), .TIMEOUT(TO)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
    .req_ready(b_ready), .send_req(b_send), .send_data(b_sdata), .txq_full(b_full),
    .grant(b_grant), .timeout_evt(b_evt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
  endtask

  // Leaves time at posedge+1 with rst low and both DUTs freshly reset.
  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b00 || a_ready !== 2'b00 || a_send !== 1'b0 || a_sdata !== 8'h00 || a_evt !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a: grant=%b ready=%b send=%b data=%h evt=%b, want all zero",
               a_grant, a_ready, a_send, a_sdata, a_evt);
    end
    n_vec++;
    if (b_grant !== 3'b000 || b_ready !== 3'b000 || b_send !== 1'b0 || b_sdata !== 8'h00 || b_evt !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b: grant=%b ready=%b send=%b data=%h evt=%b, want all zero",
               b_grant, b_ready, b_send, b_sdata, b_evt);
    end
    tick();
    a_valid = 2'b11; a_data = 16'h2211; a_last = 2'b11;
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b00 || a_ready !== 2'b00 || a_send !== 1'b0 || a_sdata !== 8'h00) begin
      n_err++;
      $display("FAIL idle_no_xfer: grant=%b ready=%b send=%b data=%h, want 00 00 0 00",
               a_grant, a_ready, a_send, a_sdata);
    end
    tick();
  endtask

  task automatic test_single();
    logic [7:0] bytes [3];
    bytes = '{8'h41, 8'h42, 8'h43};
    do_reset();
    a_valid = 2'b01; a_data = {8'h00, bytes[0]};
    @(negedge clk);
    n_vec++;
    if (a_send !== 1'b0 || a_grant !== 2'b00) begin
      n_err++;
      $display("FAIL single_arb: send=%b grant=%b, want 0 00", a_send, a_grant);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      a_data = {8'h00, bytes[i]};
      a_last = {1'b0, (i == 2)};
      @(negedge clk);
      n_vec++;
      if (a_send !== 1'b1 || a_sdata !== bytes[i] || a_grant !== 2'b01 || a_ready !== 2'b01) begin
        n_err++;
        $display("FAIL single_byte%0d: send=%b data=%h grant=%b ready=%b, want 1 %h 01 01",
                 i, a_send, a_sdata, a_grant, a_ready, bytes[i]);
      end
      tick();
    end
    a_valid = 2'b00; a_last = 2'b00;
    @(negedge clk);
    n_vec++;
    if (a_send !== 1'b0 || a_grant !== 2'b00) begin
      n_err++;
      $display("FAIL single_idle_after: send=%b grant=%b, want 0 00", a_send, a_grant);
    end
    tick();
    a_valid = 2'b11; a_data = 16'hC1C0; a_last = 2'b11;
    tick();
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b10 || a_sdata !== 8'hC1) begin
      n_err++;
      $display("FAIL single_ptr_next: grant=%b data=%h, want 10 c1", a_grant, a_sdata);
    end
    tick();
  endtask

  task automatic test_fairness();
    int         bidx [3];
    int         own;
    logic       exp_send;
    logic [7:0] exp_data;
    logic [2:0] exp_grant;
    bidx = '{0, 0, 0};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      b_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
        b_data[8*i +: 8] = 8'(16 * i + bidx[i]);
        b_last[i]        = (bidx[i] == 1);
      end
      @(negedge clk);
      // Each packet takes one arbitration cycle plus two byte cycles.
      own       = (c / 3) % 3;
      exp_send  = (c % 3) != 0;
      exp_data  = exp_send ? 8'(16 * own + (c % 3) - 1) : 8'h00;
      exp_grant = exp_send ? 3'(1 << own) : 3'b000;
      n_vec++;
      if (b_send !== exp_send || b_sdata !== exp_data || b_grant !== exp_grant) begin
        n_err++;
        $display("FAIL fair_c%0d: send=%b data=%h grant=%b, want %b %h %b",
                 c, b_send, b_sdata, b_grant, exp_send, exp_data, exp_grant);
      end
      for (int i = 0; i < 3; i++) if (b_ready[i]) bidx[i] = 1 - bidx[i];
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_valid = 2'b01; a_data = 16'h0050; a_last = 2'b00;
    tick();
    @(negedge clk);
    n_vec++;
    if (a_send !== 1'b1 || a_sdata !== 8'h50 || a_grant !== 2'b01) begin
      n_err++;
      $display("FAIL bp_first: send=%b data=%h grant=%b, want 1 50 01", a_send, a_sdata, a_grant);
    end
    tick();
    a_data = 16'h0051; a_full = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_vec++;
      if (a_send !== 1'b0 || a_ready !== 2'b00 || a_grant !== 2'b01 || a_evt !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: send=%b ready=%b grant=%b evt=%b, want 0 00 01 0",
                 k, a_send, a_ready, a_grant, a_evt);
      end
      tick();
    end
    a_full = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_send !== 1'b1 || a_sdata !== 8'h51 || a_grant !== 2'b01) begin
      n_err++;
      $display("FAIL bp_resume: send=%b data=%h grant=%b, want 1 51 01", a_send, a_sdata, a_grant);
    end
    tick();
    a_data = 16'h0052; a_last = 2'b01;
    @(negedge clk);
    n_vec++;
    if (a_send !== 1'b1 || a_sdata !== 8'h52) begin
      n_err++;
      $display("FAIL bp_last: send=%b data=%h, want 1 52", a_send, a_sdata);
    end
    tick();
    a_valid = 2'b00; a_last = 2'b00;
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b00) begin
      n_err++;
      $display("FAIL bp_release: grant=%b, want 00", a_grant);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    a_valid = 2'b11; a_data = 16'h7060; a_last = 2'b10;
    tick();
    @(negedge clk);
    n_vec++;
    if (a_send !== 1'b1 || a_sdata !== 8'h60 || a_grant !== 2'b01) begin
      n_err++;
      $display("FAIL to_first: send=%b data=%h grant=%b, want 1 60 01", a_send, a_sdata, a_grant);
    end
    tick();
    a_valid = 2'b10;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      n_vec++;
      if (a_evt !== (k == TO) || a_grant !== 2'b01 || a_send !== 1'b0 || a_ready !== 2'b01) begin
        n_err++;
        $display("FAIL to_wait%0d: evt=%b grant=%b send=%b ready=%b, want %b 01 0 01",
                 k, a_evt, a_grant, a_send, a_ready, (k == TO));
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b00 || a_evt !== 1'b0) begin
      n_err++;
      $display("FAIL to_idle: grant=%b evt=%b, want 00 0", a_grant, a_evt);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b10 || a_send !== 1'b1 || a_sdata !== 8'h70 || a_evt !== 1'b0) begin
      n_err++;
      $display("FAIL to_handover: grant=%b send=%b data=%h evt=%b, want 10 1 70 0",
               a_grant, a_send, a_sdata, a_evt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_valid = 2'b01; a_data = 16'h00A0; a_last = 2'b01;
    tick();
    @(negedge clk);
    n_vec++;
    if (a_send !== 1'b1 || a_sdata !== 8'hA0 || a_grant !== 2'b01) begin
      n_err++;
      $display("FAIL rm_pre: send=%b data=%h grant=%b, want 1 a0 01", a_send, a_sdata, a_grant);
    end
    tick();
    a_valid = 2'b10; a_data = 16'h8000; a_last = 2'b00;
    tick();
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b10 || a_sdata !== 8'h80) begin
      n_err++;
      $display("FAIL rm_owner1: grant=%b data=%h, want 10 80", a_grant, a_sdata);
    end
    tick();
    a_data = 16'h8100; rst = 1'b1;
    tick();
    rst = 1'b0; a_valid = 2'b11; a_data = 16'h80B0; a_last = 2'b00;
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b00 || a_ready !== 2'b00 || a_send !== 1'b0 || a_sdata !== 8'h00 || a_evt !== 1'b0) begin
      n_err++;
      $display("FAIL rm_cleared: grant=%b ready=%b send=%b data=%h evt=%b, want all zero",
               a_grant, a_ready, a_send, a_sdata, a_evt);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (a_grant !== 2'b01 || a_sdata !== 8'hB0) begin
      n_err++;
      $display("FAIL rm_ptr0: grant=%b data=%h, want 01 b0", a_grant, a_sdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] cur;
    logic       exp_send;
    do_reset();
    cur = 8'($urandom);
    a_valid = 2'b10; a_last = 2'b10;
    for (int c = 0; c < 16; c++) begin
      a_data = {cur, 8'h00};
      @(negedge clk);
      exp_send = (c % 2) == 1;
      n_vec++;
      if (a_send !== exp_send || a_sdata !== (exp_send ? cur : 8'h00) ||
          a_grant !== (exp_send ? 2'b10 : 2'b00)) begin
        n_err++;
        $display("FAIL b2b_c%0d: send=%b data=%h grant=%b, want %b %h %b", c, a_send, a_sdata,
                 a_grant, exp_send, (exp_send ? cur : 8'h00), (exp_send ? 2'b10 : 2'b00));
      end
      if (a_ready[1]) cur = 8'($urandom);
      tick();
    end
  endtask

  // Reference: owner (-1 = nobody), rotating pointer, and the number of consecutive
  // locked cycles in which the owner offered nothing.
  task automatic test_random();
    int         m_own, m_ptr, m_quiet;
    bit         quiet;
    logic [1:0] e_grant, e_ready;
    logic       e_send, e_evt;
    logic [7:0] e_data;
    do_reset();
    m_own = -1; m_ptr = 0; m_quiet = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      quiet  = ((cyc / 24) % 3) == 2;
      a_full = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 2; i++) begin
        a_valid[i]       = quiet ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        a_data[8*i +: 8] = 8'($urandom);
        a_last[i]        = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      e_grant = '0; e_ready = '0; e_send = 1'b0; e_data = '0; e_evt = 1'b0;
      if (m_own >= 0) begin
        e_grant = 2'(1 << m_own);
        e_ready = a_full ? 2'b00 : e_grant;
        e_send  = a_valid[m_own] && !a_full;
        e_data  = e_send ? a_data[8*m_own +: 8] : 8'h00;
        e_evt   = !a_valid[m_own] && (m_quiet == TO - 1);
      end
      n_vec++;
      if (a_grant !== e_grant || a_ready !== e_ready || a_send !== e_send ||
          a_sdata !== e_data || a_evt !== e_evt) begin
        n_err++;
        $display("FAIL rand_c%0d: grant=%b/%b ready=%b/%b send=%b/%b data=%h/%h evt=%b/%b (got/want)",
                 cyc, a_grant, e_grant, a_ready, e_ready, a_send, e_send, a_sdata, e_data, a_evt, e_evt);
      end
      if (m_own < 0) begin
        if (a_valid[m_ptr])          m_own = m_ptr;
        else if (a_valid[1 - m_ptr]) m_own = 1 - m_ptr;
        m_quiet = 0;
      end else if (e_send) begin
        m_quiet = 0;
        if (a_last[m_own]) begin
          m_ptr = (m_own + 1) % 2;
          m_own = -1;
        end
      end else if (!a_valid[m_own]) begin
        if (e_evt) begin
          m_ptr   = (m_own + 1) % 2;
          m_own   = -1;
          m_quiet = 0;
        end else begin
          m_quiet++;
        end
      end
      tick();
    end
  endtask

  initial begin
    clr_in();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
